// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter stage: PC increment,
// default reset vector and the next-PC source selector.
package pc_sequencer_pkg;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Which source feeds the PC register on the next edge.
    typedef enum logic [1:0] {
        SEQ,
        BRANCH,
        CALL,
        RET
    } pcSrc_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry so the most recent RAS_DEPTH return addresses are always kept.
// Overflow/underflow are sticky until reset.
module return_addr_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] dataIn,
    output logic [ADDR_W-1:0] dataOut,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    // When full, ptr already points at the oldest entry, so writing at ptr
    // is exactly the circular overwrite.
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(RAS_DEPTH));
    assign dataOut   = mem[ptr_reg - PTR_W'(1)];
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    // Entry storage: no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (!reset && push && !pop) begin
            mem[ptr_reg] <= dataIn;
        end
    end

    // Pointer, occupancy and sticky error flags; pop has priority over push.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (pop) begin
            if (count_reg != '0) begin
                ptr_reg   <= ptr_reg - PTR_W'(1);
                count_reg <= count_reg - CNT_W'(1);
            end else begin
                underflow_reg <= 1'b1;
            end
        end else if (push) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
            if (full) begin
                overflow_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage after the branch comparator. Chooses between
// sequential, branch, call and return sources, keeps call return addresses
// on a return-address stack, and pulses flush after every redirect.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter int               RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branchIdea,
    input  logic              fC,
    input  logic              isReturn,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic              rasEmpty,
    output logic              rasFull,
    output logic              rasOverflow,
    output logic              rasUnderflow
);
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              flush_reg, flush_next;
    logic [ADDR_W-1:0] pcSeq;
    logic [ADDR_W-1:0] targetAligned;
    logic [ADDR_W-1:0] rasTop;
    logic              rasPush;
    logic              rasPop;
    pcSrc_t            pcSrc;

    assign pcSeq         = pc_reg + ADDR_W'(PC_INC);
    assign targetAligned = {target[ADDR_W-1:2], 2'b00};
    assign pc            = pc_reg;
    assign flush         = flush_reg;

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (rasPush),
        .pop       (rasPop),
        .dataIn    (pcSeq),
        .dataOut   (rasTop),
        .full      (rasFull),
        .empty     (rasEmpty),
        .overflow  (rasOverflow),
        .underflow (rasUnderflow)
    );

    // Priority select: stall > return > branch/call > sequential. A return
    // on an empty stack still pops so the stack records the underflow.
    always_comb begin
        pcSrc      = SEQ;
        rasPop     = 1'b0;
        rasPush    = 1'b0;
        pc_next    = pcSeq;
        flush_next = 1'b0;
        if (!stall) begin
            if (isReturn) begin
                rasPop = 1'b1;
                if (!rasEmpty) begin
                    pcSrc = RET;
                end
            end else if (branchIdea) begin
                pcSrc = fC ? CALL : BRANCH;
            end
        end
        rasPush = (pcSrc == CALL);
        case (pcSrc)
            BRANCH, CALL: pc_next = targetAligned;
            RET:          pc_next = rasTop;
            default:      pc_next = pcSeq;
        endcase
        flush_next = (pcSrc != SEQ);
    end

    // PC and flush registers; a stall holds pc and drops flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            flush_reg <= 1'b0;
        end else begin
            if (!stall) begin
                pc_reg <= pc_next;
            end
            flush_reg <= flush_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, a hand-written
// RAS overflow/underflow sequence, then randomized traffic against a
// queue-based reference model of the PC stage.
module tb_pc_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, stall, branchIdea, fC, isReturn;
    logic [31:0] target;
    logic [31:0] pc;
    logic        flush, rasEmpty, rasFull, rasOverflow, rasUnderflow;

    int tests = 0;
    int fails = 0;

    // Reference model state: return stack as a queue (back = newest).
    logic [31:0] mPc;
    logic        mFlush, mOvf, mUnf;
    logic [31:0] mStack[$];

    typedef struct {
        logic        rst, stl, br, fc, ret;
        logic [31:0] tgt;
        logic [31:0] ePc;
        logic        eFlush, eEmpty, eUnf;
    } vec_t;

    vec_t tbl[26];

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W    (32),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branchIdea   (branchIdea),
        .fC           (fC),
        .isReturn     (isReturn),
        .target       (target),
        .pc           (pc),
        .flush        (flush),
        .rasEmpty     (rasEmpty),
        .rasFull      (rasFull),
        .rasOverflow  (rasOverflow),
        .rasUnderflow (rasUnderflow)
    );

    function automatic vec_t mk(input logic rst, stl, br, fc, ret, input logic [31:0] tgt,
                                input logic [31:0] ePc, input logic eFlush, eEmpty, eUnf);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.fc = fc; v.ret = ret; v.tgt = tgt;
        v.ePc = ePc; v.eFlush = eFlush; v.eEmpty = eEmpty; v.eUnf = eUnf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance the model by one edge using the input values currently driven.
    task automatic modelStep();
        if (reset) begin
            mPc = 32'h0; mFlush = 1'b0; mOvf = 1'b0; mUnf = 1'b0;
            mStack.delete();
        end else if (stall) begin
            mFlush = 1'b0;
        end else if (isReturn) begin
            if (mStack.size() > 0) begin
                mPc = mStack.pop_back();
                mFlush = 1'b1;
            end else begin
                mPc = mPc + 32'd4;
                mUnf = 1'b1;
                mFlush = 1'b0;
            end
        end else if (branchIdea) begin
            if (fC) begin
                if (mStack.size() == DEPTH) begin
                    mStack.delete(0);
                    mOvf = 1'b1;
                end
                mStack.push_back(mPc + 32'd4);
            end
            mPc = target & ~32'h3;
            mFlush = 1'b1;
        end else begin
            mPc = mPc + 32'd4;
            mFlush = 1'b0;
        end
    endtask

    // One transaction: drive inputs, clock, sample 1ns after the edge, compare to model.
    task automatic apply(input logic r, s, b, f, ret, input logic [31:0] t);
        reset = r; stall = s; branchIdea = b; fC = f; isReturn = ret; target = t;
        @(posedge clk);
        #1;
        modelStep();
        $display("[TB] rst=%0d stall=%0d br=%0d fC=%0d ret=%0d tgt=%08h -> pc=%08h flush=%0d empty=%0d full=%0d ovf=%0d unf=%0d",
                 r, s, b, f, ret, t, pc, flush, rasEmpty, rasFull, rasOverflow, rasUnderflow);
        check("model pc",    pc,                   mPc);
        check("model flush", 32'(flush),           32'(mFlush));
        check("model empty", 32'(rasEmpty),        32'(mStack.size() == 0));
        check("model full",  32'(rasFull),         32'(mStack.size() == DEPTH));
        check("model ovf",   32'(rasOverflow),     32'(mOvf));
        check("model unf",   32'(rasUnderflow),    32'(mUnf));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branchIdea = 1'b0; fC = 1'b0; isReturn = 1'b0; target = '0;
        mPc = '0; mFlush = 1'b0; mOvf = 1'b0; mUnf = 1'b0;

        //            rst stl br fc ret target        expPc         fl em unf
        tbl[0]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h4,        0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h8,        0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 32'h0,        32'hC,        0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h10,       0, 1, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 32'h103,      32'h100,      1, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h104,      0, 1, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 32'h20,       32'h20,       1, 1, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0, 32'h200,      32'h200,      1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h204,      0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 32'h0,        32'h24,       1, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 32'h0,        32'h28,       0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 1, 32'h0,        32'h2C,       0, 1, 1);
        tbl[13] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        tbl[14] = mk(0, 0, 1, 1, 0, 32'h300,      32'h300,      1, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 1, 32'h500,      32'h4,        1, 1, 0);
        tbl[16] = mk(0, 1, 1, 1, 0, 32'h600,      32'h4,        0, 1, 0);
        tbl[17] = mk(0, 0, 1, 1, 0, 32'h600,      32'h600,      1, 0, 0);
        tbl[18] = mk(1, 0, 1, 1, 0, 32'h600,      32'h0,        0, 1, 0);
        tbl[19] = mk(0, 0, 0, 1, 0, 32'h700,      32'h4,        0, 1, 0);
        tbl[20] = mk(0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFC, 1, 1, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0);
        tbl[22] = mk(0, 0, 1, 1, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0);
        tbl[23] = mk(0, 0, 1, 1, 0, 32'h10,       32'h10,       1, 0, 0);
        tbl[24] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 0, 0);
        tbl[25] = mk(0, 0, 0, 0, 1, 32'h0,        32'h4,        1, 1, 0);

        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].rst, tbl[i].stl, tbl[i].br, tbl[i].fc, tbl[i].ret, tbl[i].tgt);
            check($sformatf("vec%0d pc", i),    pc,                tbl[i].ePc);
            check($sformatf("vec%0d flush", i), 32'(flush),        32'(tbl[i].eFlush));
            check($sformatf("vec%0d empty", i), 32'(rasEmpty),     32'(tbl[i].eEmpty));
            check($sformatf("vec%0d unf", i),   32'(rasUnderflow), 32'(tbl[i].eUnf));
        end

        // Nine calls into an 8-deep stack, eight LIFO returns, one underflowing return.
        apply(1, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 9; k++) begin
            apply(0, 0, 1, 1, 0, 32'h1000 * (k + 1));
        end
        check("ovf seq full", 32'(rasFull),     32'd1);
        check("ovf seq ovf",  32'(rasOverflow), 32'd1);
        for (int k = 8; k >= 1; k--) begin
            apply(0, 0, 0, 0, 1, 32'h0);
            check($sformatf("lifo pop %0d pc", k), pc,         32'h1000 * k + 32'h4);
            check($sformatf("lifo pop %0d flush", k), 32'(flush), 32'd1);
        end
        apply(0, 0, 0, 0, 1, 32'h0);
        check("underflow pc",    pc,                32'h1008);
        check("underflow flag",  32'(rasUnderflow), 32'd1);
        check("underflow flush", 32'(flush),        32'd0);
        check("underflow empty", 32'(rasEmpty),     32'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
            apply($urandom_range(0, 59) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0,
                  t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
